// File: rtl/board_line_clear_ctrl.sv
// Line-clear sequencer for a COLSxROWS board RAM; owns the RAM port while busy.
// Define LINE_CLEAR_BONUS_EN for the tiered score table instead of score = lines.
module board_line_clear_ctrl #(
  parameter int COLS = 10,
  parameter int ROWS = 20
) (
  input  logic       CLOCK_50,
  input  logic       resetn,
  input  logic       start,
  output logic       busy,
  output logic       done,
  output logic [2:0] lines,
  output logic [3:0] score_add,
  input  logic [3:0] gl_rx,
  input  logic [4:0] gl_ry,
  output logic       gl_rdata,
  input  logic       gl_we,
  input  logic [3:0] gl_wx,
  input  logic [4:0] gl_wy,
  input  logic       gl_wdata,
  output logic [3:0] board_rx,
  output logic [4:0] board_ry,
  input  logic       board_rdata,
  output logic       board_we,
  output logic [3:0] board_wx,
  output logic [4:0] board_wy,
  output logic       board_wdata
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SCAN,
    S_SHIFT,
    S_TOP,
    S_DONE
  } state_t;

  localparam logic [3:0] C_LAST = 4'(COLS - 1);
  localparam logic [4:0] R_LAST = 5'(ROWS - 1);

  state_t     r_state, w_state_nx;
  logic [3:0] r_c, w_c_nx;
  logic [4:0] r_r, w_r_nx;
  logic [4:0] r_sr, w_sr_nx;
  logic [2:0] r_lines, w_lines_nx;

  always_ff @(posedge CLOCK_50) begin
    if (!resetn) begin
      r_state <= S_IDLE;
      r_c     <= '0;
      r_r     <= R_LAST;
      r_sr    <= '0;
      r_lines <= '0;
    end else begin
      r_state <= w_state_nx;
      r_c     <= w_c_nx;
      r_r     <= w_r_nx;
      r_sr    <= w_sr_nx;
      r_lines <= w_lines_nx;
    end
  end

  always_comb begin
    w_state_nx = r_state;
    w_c_nx     = r_c;
    w_r_nx     = r_r;
    w_sr_nx    = r_sr;
    w_lines_nx = r_lines;
    unique case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nx = S_SCAN;
          w_r_nx     = R_LAST;
          w_c_nx     = '0;
          w_lines_nx = '0;
        end
      end
      S_SCAN: begin
        if (!board_rdata) begin
          w_c_nx = '0;
          if (r_r == '0) w_state_nx = S_DONE;
          else           w_r_nx     = r_r - 5'd1;
        end else if (r_c != C_LAST) begin
          w_c_nx = r_c + 4'd1;
        end else begin
          w_lines_nx = (r_lines == 3'd7) ? r_lines : r_lines + 3'd1;
          w_sr_nx    = r_r;
          w_c_nx     = '0;
          w_state_nx = (r_r != '0) ? S_SHIFT : S_TOP;
        end
      end
      S_SHIFT: begin
        if (r_c == C_LAST) begin
          w_c_nx  = '0;
          w_sr_nx = r_sr - 5'd1;
          if (r_sr == 5'd1) w_state_nx = S_TOP;
        end else begin
          w_c_nx = r_c + 4'd1;
        end
      end
      S_TOP: begin
        if (r_c == C_LAST) begin
          w_c_nx     = '0;
          w_state_nx = S_SCAN;
        end else begin
          w_c_nx = r_c + 4'd1;
        end
      end
      S_DONE:  w_state_nx = S_IDLE;
      default: w_state_nx = S_IDLE;
    endcase
  end

  // Game logic sees the RAM only while idle; its writes are dropped otherwise.
  always_comb begin
    board_rx    = '0;
    board_ry    = '0;
    board_we    = 1'b0;
    board_wx    = '0;
    board_wy    = '0;
    board_wdata = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        board_rx    = gl_rx;
        board_ry    = gl_ry;
        board_we    = gl_we;
        board_wx    = gl_wx;
        board_wy    = gl_wy;
        board_wdata = gl_wdata;
      end
      S_SCAN: begin
        board_rx = r_c;
        board_ry = r_r;
      end
      S_SHIFT: begin
        board_rx    = r_c;
        board_ry    = r_sr - 5'd1;
        board_we    = 1'b1;
        board_wx    = r_c;
        board_wy    = r_sr;
        board_wdata = board_rdata;
      end
      S_TOP: begin
        board_we = 1'b1;
        board_wx = r_c;
      end
      default: ;
    endcase
  end

  assign gl_rdata = board_rdata;
  assign busy     = (r_state != S_IDLE);
  assign done     = (r_state == S_DONE);
  assign lines    = r_lines;

`ifdef LINE_CLEAR_BONUS_EN
  always_comb begin
    unique case (r_lines)
      3'd0:    score_add = 4'd0;
      3'd1:    score_add = 4'd1;
      3'd2:    score_add = 4'd3;
      3'd3:    score_add = 4'd5;
      default: score_add = 4'd8;
    endcase
  end
`else
  assign score_add = {1'b0, r_lines};
`endif

endmodule

// File: tb/tb_board_line_clear_ctrl.sv
// Randomized bench for board_line_clear_ctrl with a row-level clearing model.
// Honors LINE_CLEAR_BONUS_EN for the expected score.
module tb_board_line_clear_ctrl;
  localparam int COLS = 10;
  localparam int ROWS = 20;

  logic       CLOCK_50 = 1'b0;
  logic       resetn = 1'b0;
  logic       start = 1'b0;
  logic       busy, done;
  logic [2:0] lines;
  logic [3:0] score_add;
  logic [3:0] gl_rx = '0;
  logic [4:0] gl_ry = '0;
  logic       gl_rdata;
  logic       gl_we = 1'b0;
  logic [3:0] gl_wx = '0;
  logic [4:0] gl_wy = '0;
  logic       gl_wdata = 1'b0;
  logic [3:0] board_rx;
  logic [4:0] board_ry;
  logic       board_rdata;
  logic       board_we;
  logic [3:0] board_wx;
  logic [4:0] board_wy;
  logic       board_wdata;

  board_line_clear_ctrl #(.COLS(COLS), .ROWS(ROWS)) dut (
    .CLOCK_50(CLOCK_50), .resetn(resetn), .start(start),
    .busy(busy), .done(done), .lines(lines), .score_add(score_add),
    .gl_rx(gl_rx), .gl_ry(gl_ry), .gl_rdata(gl_rdata),
    .gl_we(gl_we), .gl_wx(gl_wx), .gl_wy(gl_wy), .gl_wdata(gl_wdata),
    .board_rx(board_rx), .board_ry(board_ry), .board_rdata(board_rdata),
    .board_we(board_we), .board_wx(board_wx), .board_wy(board_wy),
    .board_wdata(board_wdata)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  logic mem [ROWS][COLS];
  bit   want [ROWS][COLS];
  bit   exp_board [ROWS][COLS];
  int   checks = 0;
  int   errors = 0;
  bit   in_pass = 1'b0;

  always @(posedge CLOCK_50)
    if (board_we && int'(board_wy) < ROWS && int'(board_wx) < COLS)
      mem[board_wy][board_wx] <= board_wdata;

  assign board_rdata = (int'(board_ry) < ROWS && int'(board_rx) < COLS)
                     ? mem[board_ry][board_rx] : 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int score_of(input int l);
`ifdef LINE_CLEAR_BONUS_EN
    int tbl [5] = '{0, 1, 3, 5, 8};
    return (l > 4) ? 8 : tbl[l];
`else
    return l;
`endif
  endfunction

  always @(negedge CLOCK_50) begin
    chk("rdata_path", int'(gl_rdata), int'(board_rdata));
    if (!in_pass) begin
      chk("idle_busy", int'(busy), 0);
      chk("idle_done", int'(done), 0);
      chk("pass_rx", int'(board_rx), int'(gl_rx));
      chk("pass_ry", int'(board_ry), int'(gl_ry));
      chk("pass_we", int'(board_we), int'(gl_we));
      chk("pass_wx", int'(board_wx), int'(gl_wx));
      chk("pass_wy", int'(board_wy), int'(gl_wy));
      chk("pass_wd", int'(board_wdata), int'(gl_wdata));
    end
  end

  // Row-level model: full rows vanish, cost per row follows the pass rules.
  task automatic model(output int m_lines, output int m_cyc);
    bit b [ROWS][COLS];
    int r, nfull, fz;
    bit full;
    b = want;
    r = ROWS - 1;
    nfull = 0;
    m_cyc = 0;
    while (1) begin
      full = 1'b1;
      fz = COLS - 1;
      for (int x = COLS - 1; x >= 0; x--)
        if (!b[r][x]) begin full = 1'b0; fz = x; end
      if (full) begin
        m_cyc += 2 * COLS + r * COLS;
        nfull++;
        for (int y = r; y > 0; y--) b[y] = b[y-1];
        for (int x = 0; x < COLS; x++) b[0][x] = 1'b0;
      end else begin
        m_cyc += fz + 1;
        if (r == 0) break;
        r--;
      end
    end
    m_lines = (nfull > 7) ? 7 : nfull;
    exp_board = b;
  endtask

  task automatic clr();
    for (int y = 0; y < ROWS; y++)
      for (int x = 0; x < COLS; x++) want[y][x] = 1'b0;
  endtask

  task automatic rnd_board();
    int m;
    for (int y = 0; y < ROWS; y++) begin
      m = $urandom_range(0, 3);
      for (int x = 0; x < COLS; x++)
        want[y][x] = (m == 0) ? 1'b0 : (m == 2) ? 1'($urandom % 2) : 1'b1;
    end
  endtask

  // Writes want[] through the pass-through port; start rides on the last write.
  task automatic load_and_start();
    for (int y = 0; y < ROWS; y++)
      for (int x = 0; x < COLS; x++) begin
        gl_we = 1'b1;
        gl_wx = 4'(x);
        gl_wy = 5'(y);
        gl_wdata = want[y][x];
        start = (y == ROWS - 1 && x == COLS - 1);
        @(posedge CLOCK_50); #1;
      end
    gl_we = 1'b0;
    start = 1'b0;
    in_pass = 1'b1;
  endtask

  task automatic run_pass(input string tag, input bit noise,
                          input int lit_cyc, input int lit_lines);
    int m_lines, m_cyc, nbusy, ndone, g_lines, g_score, n, mism;
    model(m_lines, m_cyc);
    load_and_start();
    nbusy = 0; ndone = 0; g_lines = -1; g_score = -1; n = 0;
    while (n < 6000) begin
      if (noise && ndone == 0) begin
        start = ($urandom_range(0, 3) == 0);
        gl_we = 1'($urandom % 2);
        gl_wx = 4'($urandom_range(0, COLS - 1));
        gl_wy = 5'($urandom_range(0, ROWS - 1));
        gl_wdata = 1'($urandom % 2);
      end
      @(negedge CLOCK_50);
      n++;
      if (!busy) break;
      nbusy++;
      if (done) begin
        ndone++;
        g_lines = int'(lines);
        g_score = int'(score_add);
        start = 1'b0;
        gl_we = 1'b0;
      end
      @(posedge CLOCK_50); #1;
    end
    start = 1'b0;
    gl_we = 1'b0;
    in_pass = 1'b0;
    if (n >= 6000) chk({tag, "_timeout"}, n, 0);
    chk({tag, "_busy_cycles"}, nbusy, m_cyc + 1);
    chk({tag, "_done_pulses"}, ndone, 1);
    chk({tag, "_lines"}, g_lines, m_lines);
    chk({tag, "_score"}, g_score, score_of(m_lines));
    if (lit_cyc >= 0) chk({tag, "_lit_cycles"}, nbusy, lit_cyc);
    if (lit_lines >= 0) chk({tag, "_lit_lines"}, g_lines, lit_lines);
    mism = 0;
    for (int y = 0; y < ROWS; y++)
      for (int x = 0; x < COLS; x++)
        if (mem[y][x] !== exp_board[y][x]) mism++;
    chk({tag, "_board"}, mism, 0);
    repeat (2) @(posedge CLOCK_50);
    #1;
    chk({tag, "_lines_hold"}, int'(lines), m_lines);
    chk({tag, "_score_hold"}, int'(score_add), score_of(m_lines));
  endtask

  initial begin
    int n;
    repeat (3) @(posedge CLOCK_50);
    @(negedge CLOCK_50);
    chk("rst_busy", int'(busy), 0);
    chk("rst_lines", int'(lines), 0);
    chk("rst_score", int'(score_add), 0);
    @(posedge CLOCK_50); #1;
    resetn = 1'b1;

    clr();
    run_pass("empty", 1'b0, 21, 0);

    clr();
    for (int x = 0; x < COLS; x++) want[19][x] = 1'b1;
    want[18][0] = 1'b1;
    run_pass("row19", 1'b0, 232, 1);
    chk("row19_x0", int'(mem[19][0]), 1);
    chk("row19_x1", int'(mem[19][1]), 0);

    clr();
    for (int x = 0; x < COLS; x++) begin
      want[19][x] = 1'b1;
      want[18][x] = 1'b1;
    end
    run_pass("rows18_19", 1'b0, 441, 2);
`ifdef LINE_CLEAR_BONUS_EN
    chk("rows18_19_lit_score", int'(score_add), 3);
`else
    chk("rows18_19_lit_score", int'(score_add), 2);
`endif

    clr();
    for (int x = 0; x < COLS; x++) want[0][x] = 1'b1;
    run_pass("row0", 1'b0, 41, 1);
    chk("row0_x9", int'(mem[0][9]), 0);

    rnd_board();
    run_pass("noise", 1'b1, -1, -1);

    for (int i = 0; i < 12; i++) begin
      rnd_board();
      run_pass($sformatf("rnd%0d", i), 1'($urandom % 2), -1, -1);
    end

    rnd_board();
    for (int x = 0; x < COLS; x++) want[19][x] = 1'b1;
    load_and_start();
    n = 0;
    while (n < 500) begin
      @(negedge CLOCK_50);
      n++;
      if (board_we && board_wy != 5'd0) break;
    end
    if (n >= 500) chk("rst_mid_timeout", n, 0);
    @(posedge CLOCK_50); #1;
    resetn = 1'b0;
    @(posedge CLOCK_50); #1;
    in_pass = 1'b0;
    gl_rx = 4'd3;
    gl_ry = 5'd7;
    gl_we = 1'b1;
    gl_wx = 4'd2;
    gl_wy = 5'd5;
    gl_wdata = 1'b1;
    @(negedge CLOCK_50);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_lines", int'(lines), 0);
    chk("midrst_done", int'(done), 0);
    chk("midrst_rx", int'(board_rx), 3);
    chk("midrst_ry", int'(board_ry), 7);
    chk("midrst_we", int'(board_we), 1);
    @(posedge CLOCK_50); #1;
    gl_we = 1'b0;
    chk("midrst_write", int'(mem[5][2]), 1);
    resetn = 1'b1;
    repeat (2) @(posedge CLOCK_50);
    #1;
    chk("post_rst_busy", int'(busy), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
